// File: rtl/multiplier_word_pkg.sv
// ---------------------------------------------------------------------------
// multiplier_word_pkg
//
// Purpose:
//   Shared definitions for the iterative shift-add multiplier: FSM state
//   encodings, the iteration count and the width of the iteration counter.
//   The package takes the place of a guarded include header, so every file
//   that needs these names simply imports multiplier_word_pkg::*.
//
// Contents:
//   MUL_ITER    - number of add/shift iterations per operation (32)
//   MUL_CNT_W   - width of the iteration counter (6, holds 0..32)
//   MUL_LAST    - counter value of the final iteration
//   mul_state_e - 2-bit state encoding MUL_IDLE/MUL_RUN/MUL_FIX/MUL_DONE
//   mag32()     - 32-bit two's complement magnitude helper
// ---------------------------------------------------------------------------
package multiplier_word_pkg;

  localparam int MUL_ITER  = 32;
  localparam int MUL_CNT_W = 6;

  localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_ITER - 1);

  // MUL_FIX is only ever entered when the signed option is compiled in; its
  // encoding is reserved in the unsigned build so both builds share one map.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_FIX  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

  // Magnitude of a 32-bit two's complement value. The most negative value
  // maps onto itself, which read as unsigned is exactly its magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/adder_word.sv
// ---------------------------------------------------------------------------
// adder_word
//
// Purpose:
//   32-bit word adder with carry in and carry out. This is the only
//   arithmetic resource the multiplier uses for its partial-product sums.
//
// Ports:
//   a         in  32  first addend
//   b         in  32  second addend
//   carry_in  in   1  carry into bit 0
//   sum       out 32  low 32 bits of a + b + carry_in
//   carry_out out  1  carry out of bit 31
// ---------------------------------------------------------------------------
module adder_word (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out
);

  // Extend to 33 bits so the carry out falls naturally into the top bit.
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, carry_in};

endmodule

// File: rtl/multiplier_word.sv
// ---------------------------------------------------------------------------
// multiplier_word
//
// Purpose:
//   Iterative shift-add 32x32 -> 64 unsigned multiplier for the execute
//   stage. One conditional add per clock through a single adder_word,
//   32 iterations per operation. The control unit launches an operation
//   with start while ready is high and collects the product on done.
//
//   Timing: start accepted in cycle N -> done pulses in cycle N+33
//   (N+34 when SIGNED_MUL_EN is defined). One operation at a time, no
//   queueing; start while not ready is ignored.
//
// Optional feature (macro SIGNED_MUL_EN):
//   Adds the signed_op input. Signed operands are converted to magnitudes
//   at capture, the sign of the result is remembered, and an extra FIX
//   cycle negates the 64-bit result when needed. Every operation then
//   takes the FIX cycle, so latency stays uniform.
//
// Parameters:
//   WIDTH     operand width; only 32 is legal (adder_word is 32 bits)
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous, active-low reset
//   start      in   1   launch request, sampled only while ready=1
//   signed_op  in   1   (SIGNED_MUL_EN only) treat a and b as signed
//   a          in  32   multiplicand, captured on accepted start
//   b          in  32   multiplier, captured on accepted start
//   ready      out  1   idle, start will be accepted
//   busy       out  1   iteration (or sign fix-up) in progress
//   done       out  1   one-cycle pulse when product is valid
//   product    out 64   result, held from done until the next result
// ---------------------------------------------------------------------------
module multiplier_word
  import multiplier_word_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
`ifdef SIGNED_MUL_EN
  input  logic               signed_op,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // adder_word is hard-wired to 32 bits, so any other width is a build error.
  generate
    if (WIDTH != 32) begin : g_width_check
      $error("multiplier_word: WIDTH must be 32, got %0d", WIDTH);
    end
  endgenerate

  mul_state_e           r_state;
  mul_state_e           w_next_state;

  logic [31:0]          r_mcand;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;
  logic [MUL_CNT_W-1:0] r_count;
  logic [63:0]          r_product;

`ifdef SIGNED_MUL_EN
  logic                 r_neg;
`endif

  logic [31:0]          w_sum;
  logic                 w_carry;
  logic [31:0]          w_add_hi;
  logic                 w_add_c;
  logic [31:0]          w_next_hi;
  logic [31:0]          w_next_lo;
  logic                 w_last_iter;

  // The single arithmetic resource: hi + mcand, carry in tied low.
  adder_word u_adder (
    .a         (r_hi),
    .b         (r_mcand),
    .carry_in  (1'b0),
    .sum       (w_sum),
    .carry_out (w_carry)
  );

  // Select the add result only when the current multiplier bit is set. The
  // carry out must ride into the top of hi on the shift, otherwise large
  // products such as 0xFFFFFFFF squared lose their upper bit.
  assign w_add_hi    = r_lo[0] ? w_sum : r_hi;
  assign w_add_c     = r_lo[0] & w_carry;
  assign w_next_hi   = {w_add_c, w_add_hi[31:1]};
  assign w_next_lo   = {w_add_hi[0], r_lo[31:1]};
  assign w_last_iter = (r_count == MUL_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE waits for start, RUN counts 32 iterations, the
  // optional FIX applies the sign, DONE lasts exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MUL_IDLE: begin
        if (start) begin
          w_next_state = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (w_last_iter) begin
`ifdef SIGNED_MUL_EN
          w_next_state = MUL_FIX;
`else
          w_next_state = MUL_DONE;
`endif
        end
      end
`ifdef SIGNED_MUL_EN
      MUL_FIX: begin
        w_next_state = MUL_DONE;
      end
`endif
      MUL_DONE: begin
        w_next_state = MUL_IDLE;
      end
      default: begin
        w_next_state = MUL_IDLE;
      end
    endcase
  end

  // Datapath. Operands are captured only on an accepted start, so a and b
  // are free to change afterwards. The product register is written only
  // on the edge that enters DONE and holds its value at all other times.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_count   <= '0;
      r_product <= '0;
`ifdef SIGNED_MUL_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (start) begin
`ifdef SIGNED_MUL_EN
            r_mcand <= signed_op ? mag32(a) : a;
            r_lo    <= signed_op ? mag32(b) : b;
            r_neg   <= signed_op & (a[31] ^ b[31]);
`else
            r_mcand <= a;
            r_lo    <= b;
`endif
            r_hi    <= '0;
            r_count <= '0;
          end
        end
        MUL_RUN: begin
          r_hi    <= w_next_hi;
          r_lo    <= w_next_lo;
          r_count <= r_count + 1'b1;
`ifndef SIGNED_MUL_EN
          if (w_last_iter) begin
            r_product <= {w_next_hi, w_next_lo};
          end
`endif
        end
`ifdef SIGNED_MUL_EN
        MUL_FIX: begin
          r_product <= r_neg ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Status outputs decode directly from the state register.
  assign ready   = (r_state == MUL_IDLE);
`ifdef SIGNED_MUL_EN
  assign busy    = (r_state == MUL_RUN) || (r_state == MUL_FIX);
`else
  assign busy    = (r_state == MUL_RUN);
`endif
  assign done    = (r_state == MUL_DONE);
  assign product = r_product;

endmodule
